// File: rtl/qpsk_sym_packetizer.sv
// qpsk_sym_packetizer
// Packs the free-running QPSK symbol stream ({I,Q} per strobe) into
// fixed-length AXI-stream packets. The newest symbol is held until its
// tlast is known, partial packets are flushed on idle timeout or when
// enable drops, and an output FIFO absorbs downstream backpressure.
// Because the symbol loop cannot be stalled, symbols that find the FIFO
// full are dropped and counted.
module qpsk_sym_packetizer #(
  parameter int WIDTH       = 32,
  parameter int FIFO_AWIDTH = 5,
  parameter int TIMEOUT_W   = 16
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [15:0]          spp,
  input  logic [TIMEOUT_W-1:0] timeout,
  input  logic                 sym_stb,
  input  logic [WIDTH-1:0]     sym_tdata,
  output logic [WIDTH-1:0]     o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [31:0]          overflow_cnt,
  output logic                 busy
);

  localparam int DEPTH = 1 << FIFO_AWIDTH;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } fifo_word_t;

  // FIFO storage and pointers; pointers carry one extra wrap bit so that
  // full and empty are distinguishable without a separate count register.
  fifo_word_t           mem [DEPTH];
  logic [FIFO_AWIDTH:0] wr_ptr;
  logic [FIFO_AWIDTH:0] rd_ptr;
  logic [FIFO_AWIDTH:0] fifo_cnt;
  logic [FIFO_AWIDTH:0] wr_ptr_nxt;
  logic [FIFO_AWIDTH:0] rd_ptr_nxt;
  logic                 fifo_full;
  logic                 fifo_empty;

  // Holding register and packet bookkeeping
  logic                 hold_valid;
  logic [WIDTH-1:0]     hold_data;
  logic [15:0]          pkt_cnt;
  logic [15:0]          spp_l;
  logic [TIMEOUT_W-1:0] idle_cnt;

  // Per-cycle decode
  logic                 accept;
  logic                 timeout_hit;
  logic                 flush;
  logic                 push_req;
  logic                 push_ok;
  logic                 push_last;
  logic                 acc_last;
  logic                 pop;
  logic                 drop;
  logic [15:0]          spp_eff;
  logic [15:0]          cur_spp;
  logic                 hold_valid_nxt;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign fifo_full  = fifo_cnt[FIFO_AWIDTH];
  assign fifo_empty = (wr_ptr == rd_ptr);

  // spp of 0 or 1 both mean single-symbol packets.
  assign spp_eff = (spp == 16'd0) ? 16'd1 : spp;
  // The first push of a packet uses the live spp (that is when spp_l
  // latches it); later pushes use the latched value so a mid-packet spp
  // change only affects the next packet.
  assign cur_spp  = (pkt_cnt == 16'd0) ? spp_eff : spp_l;
  assign acc_last = (pkt_cnt == cur_spp - 16'd1);

  assign accept      = sym_stb & enable;
  assign timeout_hit = (timeout != '0) && (idle_cnt == timeout - TIMEOUT_W'(1));
  // An accept always wins over a flush in the same cycle.
  assign flush       = hold_valid & ~accept & (~enable | timeout_hit);
  assign push_req    = (accept & hold_valid) | flush;
  assign push_last   = flush | acc_last;
  // Full is judged before any same-cycle pop.
  assign push_ok     = push_req & ~fifo_full;
  assign drop        = accept & hold_valid & fifo_full;
  assign pop         = o_tvalid & o_tready;

  assign wr_ptr_nxt  = wr_ptr + {{FIFO_AWIDTH{1'b0}}, push_ok};
  assign rd_ptr_nxt  = rd_ptr + {{FIFO_AWIDTH{1'b0}}, pop};

  // Next value of hold_valid: a new symbol always lands in hold; a
  // successful flush empties it; a flush that hits a full FIFO keeps it.
  always_comb begin
    // NOTE: a default assignment first keeps this combinational block from
    // inferring a latch on any path that does not otherwise assign.
    hold_valid_nxt = hold_valid;
    if (accept) begin
      hold_valid_nxt = 1'b1;
    end else if (flush && !fifo_full) begin
      hold_valid_nxt = 1'b0;
    end
  end

  // FIFO write port; the array is intentionally left out of reset.
  always_ff @(posedge ce_clk) begin
    // NOTE: the storage array gets no reset; the pointers alone define
    // which entries are meaningful, and a reset array would cost a flop
    // per bit instead of a RAM.
    if (push_ok && !clear) begin
      mem[wr_ptr[FIFO_AWIDTH-1:0]] <= '{last: push_last, data: hold_data};
    end
  end

  // Control state: pointers, hold, packet/idle counters, overflow, busy.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the same pre-edge values regardless of statement order.
    if (ce_rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      pkt_cnt      <= '0;
      spp_l        <= '0;
      idle_cnt     <= '0;
      overflow_cnt <= '0;
      busy         <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      pkt_cnt      <= '0;
      spp_l        <= '0;
      idle_cnt     <= '0;
      overflow_cnt <= '0;
      busy         <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      hold_valid <= hold_valid_nxt;
      busy       <= hold_valid_nxt | (wr_ptr_nxt != rd_ptr_nxt);

      if (accept) begin
        hold_data <= sym_tdata;
      end

      // Packet position advances only when a word really enters the FIFO,
      // so dropped symbols never shorten a packet.
      if (push_ok) begin
        if (pkt_cnt == 16'd0) begin
          spp_l <= spp_eff;
        end
        pkt_cnt <= push_last ? 16'd0 : pkt_cnt + 16'd1;
      end

      // Idle counter stops at the expiry value so a flush blocked by a
      // full FIFO is retried every cycle until it succeeds.
      if (accept || (flush && !fifo_full)) begin
        idle_cnt <= '0;
      end else if (hold_valid && !timeout_hit && (idle_cnt != '1)) begin
        idle_cnt <= idle_cnt + TIMEOUT_W'(1);
      end

      if (drop && (overflow_cnt != '1)) begin
        overflow_cnt <= overflow_cnt + 32'd1;
      end
    end
  end

  // Registered first-word-fall-through output stage. It mirrors the head
  // entry (it is not an extra slot), looking only at words written before
  // this edge, which gives the one-cycle push-to-valid latency.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else if (clear) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end else if (wr_ptr != rd_ptr_nxt) begin
      o_tvalid <= 1'b1;
      o_tlast  <= mem[rd_ptr_nxt[FIFO_AWIDTH-1:0]].last;
      o_tdata  <= mem[rd_ptr_nxt[FIFO_AWIDTH-1:0]].data;
    end else begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
    end
  end

  // A stalled beat must hold its payload until it is taken.
  a_stall_stable : assert property (
    @(posedge ce_clk) disable iff (ce_rst)
      (o_tvalid && !o_tready && !clear) |=>
        (o_tvalid && $stable(o_tdata) && $stable(o_tlast)));

  // A presented beat always means the block reports busy.
  a_valid_busy : assert property (
    @(posedge ce_clk) disable iff (ce_rst) o_tvalid |-> busy);

  // Any unused pointer state would show up here as an impossible count.
  a_cnt_range : assert property (
    @(posedge ce_clk) disable iff (ce_rst) fifo_cnt <= (FIFO_AWIDTH+1)'(DEPTH));

endmodule

// File: tb/tb_qpsk_sym_packetizer.sv
// tb_qpsk_sym_packetizer
// Directed scenarios with hand-computed expected beats. Stimulus pushes
// the expected {last,data} into a queue; a monitor pops and compares on
// every accepted output beat.
module tb_qpsk_sym_packetizer;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] spp = 16'd4;
  logic [15:0] timeout = 16'd0;
  logic        sym_stb = 1'b0;
  logic [31:0] sym_tdata = 32'd0;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic [31:0] overflow_cnt;
  logic        busy;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_pop_cyc = 0;
  int    mark_cyc = 0;

  qpsk_sym_packetizer #(
    .WIDTH(32),
    .FIFO_AWIDTH(5),
    .TIMEOUT_W(16)
  ) dut (
    .ce_clk(ce_clk),
    .ce_rst(ce_rst),
    .clear(clear),
    .enable(enable),
    .spp(spp),
    .timeout(timeout),
    .sym_stb(sym_stb),
    .sym_tdata(sym_tdata),
    .o_tdata(o_tdata),
    .o_tlast(o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .overflow_cnt(overflow_cnt),
    .busy(busy)
  );

  always #5 ce_clk = ~ce_clk;

  always @(posedge ce_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic l);
    beat_t b;
    b.last = l;
    b.data = d;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge ce_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [31:0] d);
    sym_tdata = d;
    sym_stb   = 1'b1;
    tick();
    sym_stb   = 1'b0;
  endtask

  task automatic wait_drain(input int limit, input string tag);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < limit) begin
      tick();
      i++;
    end
    check({"drain_", tag}, exp_q.size(), 0);
  endtask

  // Monitor: a beat is transferred at the next posedge when valid and
  // ready are both high at the preceding negedge.
  always @(negedge ce_clk) begin
    if (!ce_rst && o_tvalid && o_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: actual data 0x%0h last %0b, required no beat", o_tdata, o_tlast);
      end else begin
        mon_b = exp_q.pop_front();
        check("beat_data", o_tdata, mon_b.data);
        check("beat_last", 32'(o_tlast), 32'(mon_b.last));
        last_pop_cyc = cyc;
      end
    end
  end

  // Scenario 1: 9 spaced strobes, spp=4, then enable drop flushes word 9.
  task automatic scen1(input string tag);
    spp      = 16'd4;
    timeout  = 16'd0;
    enable   = 1'b1;
    o_tready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i >= 2) expect_beat(32'(i - 1), ((i - 1) % 4) == 0);
      strobe(32'(i));
      ticks(15);
    end
    wait_drain(20, {tag, "_8beats"});
    check({tag, "_busy_held"}, 32'(busy), 32'd1);
    check({tag, "_ovf"}, overflow_cnt, 32'd0);
    expect_beat(32'd9, 1'b1);
    enable = 1'b0;
    ticks(3);
    enable = 1'b1;
    wait_drain(10, {tag, "_flush"});
    ticks(2);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_valid_idle"}, 32'(o_tvalid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    ce_rst = 1'b1;
    ticks(3);
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tlast", 32'(o_tlast), 32'd0);
    check("rst_tdata", o_tdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", overflow_cnt, 32'd0);
    ce_rst = 1'b0;
    ticks(2);

    // 1: basic packetization
    scen1("s1");

    // 2: idle timeout flush of a partial packet
    spp = 16'd4; timeout = 16'd20; enable = 1'b1; o_tready = 1'b1;
    expect_beat(32'h0000_00A0, 1'b0);
    strobe(32'h0000_00A0);
    ticks(2);
    expect_beat(32'h0000_00B0, 1'b1);
    strobe(32'h0000_00B0);
    mark_cyc = cyc;
    ticks(30);
    check("s2_flush_delay", last_pop_cyc - mark_cyc, 21);
    wait_drain(5, "s2_ab");
    for (int i = 0; i < 4; i++) begin
      expect_beat(32'hC0 + 32'(i), i == 3);
      strobe(32'hC0 + 32'(i));
      ticks(1);
    end
    wait_drain(40, "s2_pkt");

    // 3: backpressure, full FIFO, overflow counting, gapless drain
    timeout = 16'd0; o_tready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i >= 2 && i <= 33) expect_beat(32'h100 + 32'(i - 1), ((i - 1) % 4) == 0);
      strobe(32'h100 + 32'(i));
    end
    ticks(2);
    check("s3_ovf", overflow_cnt, 32'd7);
    check("s3_valid_stall", 32'(o_tvalid), 32'd1);
    check("s3_head_data", o_tdata, 32'h101);
    ticks(3);
    check("s3_head_stable", o_tdata, 32'h101);
    o_tready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge ce_clk);
      check("s3_no_gap", 32'(o_tvalid), 32'd1);
    end
    wait_drain(5, "s3_fifo");
    expect_beat(32'h100 + 32'd40, 1'b1);
    enable = 1'b0;
    ticks(2);
    enable = 1'b1;
    wait_drain(10, "s3_hold");
    check("s3_ovf_after", overflow_cnt, 32'd7);

    // 4: strobe on the expiry cycle wins over the flush
    timeout = 16'd20; spp = 16'd4; o_tready = 1'b1;
    expect_beat(32'h0000_0D01, 1'b0);
    strobe(32'h0000_0D01);
    ticks(19);
    expect_beat(32'h0000_0D02, 1'b1);
    strobe(32'h0000_0D02);
    mark_cyc = cyc;
    ticks(30);
    check("s4_restart_delay", last_pop_cyc - mark_cyc, 21);
    wait_drain(5, "s4");

    // 5: clear drops queued beats, overflow count and packet position
    timeout = 16'd0; o_tready = 1'b0;
    for (int i = 0; i < 4; i++) strobe(32'hE0 + 32'(i));
    ticks(2);
    check("s5_pre_valid", 32'(o_tvalid), 32'd1);
    check("s5_pre_ovf", overflow_cnt, 32'd7);
    clear = 1'b1;
    exp_q.delete();
    tick();
    clear = 1'b0;
    check("s5_valid_cleared", 32'(o_tvalid), 32'd0);
    check("s5_ovf_cleared", overflow_cnt, 32'd0);
    check("s5_busy_cleared", 32'(busy), 32'd0);
    o_tready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      expect_beat(32'hF0 + 32'(i), (i == 3) || (i == 4));
      strobe(32'hF0 + 32'(i));
      ticks(1);
    end
    enable = 1'b0;
    ticks(2);
    enable = 1'b1;
    wait_drain(10, "s5");

    // 6: asynchronous reset between clock edges
    spp = 16'd4; timeout = 16'd0; o_tready = 1'b0;
    strobe(32'h600D_0001);
    strobe(32'h600D_0002);
    strobe(32'h600D_0003);
    ticks(2);
    check("s6_pre_valid", 32'(o_tvalid), 32'd1);
    #2;
    ce_rst = 1'b1;
    #1;
    check("s6_rst_tvalid", 32'(o_tvalid), 32'd0);
    check("s6_rst_tlast", 32'(o_tlast), 32'd0);
    check("s6_rst_tdata", o_tdata, 32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    @(posedge ce_clk);
    #3;
    ce_rst = 1'b0;
    o_tready = 1'b1;
    tick();
    scen1("s6");

    // 7: spp=0 means one symbol per packet
    spp = 16'd0; timeout = 16'd0; o_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_beat(32'h70 + 32'(i), 1'b1);
      strobe(32'h70 + 32'(i));
      ticks(1);
    end
    enable = 1'b0;
    ticks(2);
    enable = 1'b1;
    wait_drain(10, "s7");

    ticks(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
